// File: rtl/ps2_key_event_ctrl.sv
// PS/2 byte sequencer: strips E0/F0/E1 prefixes and status bytes, queues make/break events in a FIFO.
// Optional typematic-repeat suppression is enabled with `define KEY_REPEAT_FILTER_EN.
module ps2_key_event_ctrl #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       ev_ready,
  output logic       ev_valid,
  output logic [7:0] scancode,
  output logic       ev_ext,
  output logic       push_down,
  output logic       push_up,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK, S_SKIP} state_t;

  state_t        state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] to_q, to_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic [9:0]    mem_q [DEPTH];

  logic emit, emit_brk, emit_ext;
  logic drop, accept, pop, full, empty;
  logic [9:0] head;

  function automatic logic is_status(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_status = 1'b1;
      default: is_status = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    emit     = 1'b0;
    emit_brk = 1'b0;
    emit_ext = 1'b0;
    to_d     = (state_q == S_IDLE || rx_valid) ? '0 : to_q + 1'b1;
    if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (rx_byte == 8'hE0) state_d = S_EXT;
          else if (rx_byte == 8'hF0) state_d = S_BRK;
          else if (rx_byte == 8'hE1) begin
            state_d = S_SKIP;
            skip_d  = 3'd7;
          end else if (!is_status(rx_byte)) emit = 1'b1;
        end
        S_EXT: begin
          if (rx_byte == 8'hF0) state_d = S_EXTBRK;
          else if (rx_byte == 8'hE0) state_d = S_EXT;
          else begin
            state_d  = S_IDLE;
            emit     = (rx_byte != 8'h12);
            emit_ext = 1'b1;
          end
        end
        S_BRK: begin
          state_d  = S_IDLE;
          emit     = 1'b1;
          emit_brk = 1'b1;
        end
        S_EXTBRK: begin
          state_d  = S_IDLE;
          emit     = (rx_byte != 8'h12);
          emit_brk = 1'b1;
          emit_ext = 1'b1;
        end
        S_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && to_q == TW'(TIMEOUT_CYCLES)) begin
      // stale prefix: abandon the partial sequence
      state_d = S_IDLE;
      to_d    = '0;
    end
  end

`ifdef KEY_REPEAT_FILTER_EN
  logic       last_vld_q, last_vld_d;
  logic [8:0] last_key_q, last_key_d;

  always_comb begin
    drop       = emit && !emit_brk && last_vld_q && (last_key_q == {emit_ext, rx_byte});
    last_vld_d = last_vld_q;
    last_key_d = last_key_q;
    if (accept && !emit_brk) begin
      last_vld_d = 1'b1;
      last_key_d = {emit_ext, rx_byte};
    end else if (accept && last_vld_q && last_key_q == {emit_ext, rx_byte}) begin
      last_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_vld_q <= 1'b0;
      last_key_q <= '0;
    end else begin
      last_vld_q <= last_vld_d;
      last_key_q <= last_key_d;
    end
  end
`else
  assign drop = 1'b0;
`endif

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop    = !empty && ev_ready;
  assign accept = emit && !drop && (!full || pop);
  assign head   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(accept);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    overflow_d = overflow_q | (emit && !drop && full && !pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      skip_q     <= '0;
      to_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      to_q       <= to_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q[AW-1:0]] <= {emit_brk, emit_ext, rx_byte};
  end

  // storage is not reset, so the head is masked while the FIFO is empty
  assign ev_valid  = !empty;
  assign scancode  = ev_valid ? head[7:0] : 8'h00;
  assign ev_ext    = ev_valid & head[8];
  assign push_down = pop & ~head[9];
  assign push_up   = pop & head[9];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl; popped events are logged as {break, ext, code}.
module tb_ps2_key_event_ctrl;
  localparam int DEPTH = 4;
  localparam int TMO   = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       ev_ready = 1'b0;
  logic       ev_valid, ev_ext, push_down, push_up, overflow;
  logic [7:0] scancode;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [9:0] log_q[$];

  ps2_key_event_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .ev_ready(ev_ready), .ev_valid(ev_valid), .scancode(scancode),
    .ev_ext(ev_ext), .push_down(push_down), .push_up(push_up), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (push_down || push_up) log_q.push_back({push_up, ev_ext, scancode});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else pass_cnt++;
  endtask

  function automatic logic [31:0] ent(input int i);
    return (i < log_q.size()) ? {22'd0, log_q[i]} : 32'hDEAD;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_byte = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    log_q.delete();
  endtask

  initial begin
    cycles(3);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_push_down", push_down, 0);
    check("rst_push_up", push_up, 0);
    check("rst_overflow", overflow, 0);
    check("rst_scancode", scancode, 8'h00);
    check("rst_ev_ext", ev_ext, 0);
    rst_n = 1'b1;
    ev_ready = 1'b1;
    cycles(2);
    check("empty_ready_down", push_down, 0);
    check("empty_ready_up", push_up, 0);

    // plain make and break
    send(8'h1C); send(8'hF0); send(8'h1C); cycles(3);
    check("mb_count", log_q.size(), 2);
    check("mb_make", ent(0), {2'b00, 8'h1C});
    check("mb_break", ent(1), {2'b10, 8'h1C});
    log_q.delete();

    // extended make/break and fake shift
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h12); cycles(3);
    check("ext_count", log_q.size(), 2);
    check("ext_make", ent(0), {2'b01, 8'h75});
    check("ext_break", ent(1), {2'b11, 8'h75});
    log_q.delete();

    // pause sequence swallowed
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); send(8'h29); cycles(3);
    check("pause_count", log_q.size(), 1);
    check("pause_after", ent(0), {2'b00, 8'h29});
    log_q.delete();

    // overflow and in-order drain
    ev_ready = 1'b0;
    check("lat_before", ev_valid, 0);
    send(8'h15);
    check("lat_after", ev_valid, 1);
    check("head_code", scancode, 8'h15);
    send(8'h1D); send(8'h24); send(8'h2D);
    check("full_no_ovf", overflow, 0);
    send(8'h2C);
    check("ovf_set", overflow, 1);
    ev_ready = 1'b1;
    cycles(6);
    check("drain_count", log_q.size(), 4);
    check("drain0", ent(0), {2'b00, 8'h15});
    check("drain1", ent(1), {2'b00, 8'h1D});
    check("drain2", ent(2), {2'b00, 8'h24});
    check("drain3", ent(3), {2'b00, 8'h2D});
    check("drain_empty", ev_valid, 0);
    check("ovf_sticky", overflow, 1);

    // emit while full with a simultaneous pop is accepted
    do_reset();
    check("ovf_cleared", overflow, 0);
    ev_ready = 1'b0;
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
    @(posedge clk); #1;
    rx_byte = 8'h2C; rx_valid = 1'b1; ev_ready = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; ev_ready = 1'b0;
    check("fullpop_no_ovf", overflow, 0);
    check("fullpop_head", scancode, 8'h1D);
    ev_ready = 1'b1;
    cycles(6);
    check("fullpop_count", log_q.size(), 5);
    check("fullpop_last", ent(4), {2'b00, 8'h2C});
    log_q.delete();

    // prefix timeout
    send(8'hE0); cycles(TMO + 5); send(8'h1C); cycles(3);
    check("tmo_count", log_q.size(), 1);
    check("tmo_make", ent(0), {2'b00, 8'h1C});

    // reset between F0 and code
    send(8'hF0);
    do_reset();
    send(8'h1C); cycles(3);
    check("rstmid_count", log_q.size(), 1);
    check("rstmid_make", ent(0), {2'b00, 8'h1C});
    ev_ready = 1'b0;
    send(8'h33); send(8'h34);
    do_reset();
    check("rstfifo_valid", ev_valid, 0);
    ev_ready = 1'b1;
    cycles(3);
    check("rstfifo_none", log_q.size(), 0);

    // typematic repeat
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C); cycles(3);
`ifdef KEY_REPEAT_FILTER_EN
    check("rep_count", log_q.size(), 3);
    check("rep0", ent(0), {2'b00, 8'h1C});
    check("rep1", ent(1), {2'b10, 8'h1C});
    check("rep2", ent(2), {2'b00, 8'h1C});
    check("rep_no_ovf", overflow, 0);
`else
    check("rep_count", log_q.size(), 5);
    check("rep0", ent(0), {2'b00, 8'h1C});
    check("rep2", ent(2), {2'b00, 8'h1C});
    check("rep3", ent(3), {2'b10, 8'h1C});
    check("rep4", ent(4), {2'b00, 8'h1C});
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
